// File: rtl/store_buf_pkg.sv
// Shared widths and the entry payload for the posted-write store buffer.
package store_buf_pkg;

  localparam int unsigned DEPTH_DEFAULT = 4;
  localparam int unsigned ADDR_W        = 32;
  localparam int unsigned DATA_W        = 32;
  localparam int unsigned PTR_W         = $clog2(DEPTH_DEFAULT);

  // One buffered store
  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/store_buf_match.sv
// Youngest-match search over the live window [head, head+count) of the store buffer.
// Used both for load forwarding and, when enabled, for store coalescing.
module store_buf_match
  import store_buf_pkg::*;
#(
  parameter  int unsigned DEPTH = DEPTH_DEFAULT,
  localparam int unsigned PW    = $clog2(DEPTH)
) (
  input  entry_t [DEPTH-1:0] entries,
  input  logic   [PW-1:0]    head,
  input  logic   [PW:0]      count,
  input  logic   [ADDR_W-1:0] lookup_addr,
  output logic               hit,
  output logic   [PW-1:0]    hit_index,
  output logic   [DATA_W-1:0] hit_data
);

  // Walk oldest to youngest so the last match seen is the youngest one
  always_comb begin
    logic [PW-1:0] idx;
    hit       = 1'b0;
    hit_index = '0;
    hit_data  = '0;
    idx       = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if ((i < 32'(count)) && entries[idx].valid && (entries[idx].addr == lookup_addr)) begin
        hit       = 1'b1;
        hit_index = idx;
        hit_data  = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer between the M-stage dmem port and synchronous data memory.
// Stores enqueue in one cycle and drain in FIFO order under mem_ready; loads own the
// memory port and see the youngest buffered store to their address.
// Optional: STORE_BUF_COALESCE_EN merges a store into a live entry with the same address.
module store_buffer
  import store_buf_pkg::*;
#(
  parameter  int unsigned DEPTH = DEPTH_DEFAULT,
  localparam int unsigned PW    = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] proc_address,
  input  logic [DATA_W-1:0] proc_data,
  input  logic              proc_wren,
  input  logic              proc_rden,
  output logic [DATA_W-1:0] proc_q,
  output logic              proc_stall,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_q,
  output logic [PW:0]       count
);

  entry_t [DEPTH-1:0] entries;
  logic   [PW-1:0]    head;
  logic   [PW-1:0]    tail;
  logic               fwd_hit_r;
  logic [DATA_W-1:0]  fwd_data_r;

  logic               load_c;
  logic               pop_c;
  logic               alloc_c;
  logic               coal_c;
  logic               hit_c;
  logic   [PW-1:0]    hit_idx_c;
  logic [DATA_W-1:0]  hit_data_c;

  // Single lookup serves both loads and coalescing: both use proc_address
  store_buf_match #(.DEPTH(DEPTH)) u_match (
    .entries     (entries),
    .head        (head),
    .count       (count),
    .lookup_addr (proc_address),
    .hit         (hit_c),
    .hit_index   (hit_idx_c),
    .hit_data    (hit_data_c)
  );

  // Full flag ignores a same-cycle pop to keep the stall path short
  assign proc_stall = (count == (PW+1)'(DEPTH));

  // Forwarded data wins over memory for the cycle after a hitting load
  assign proc_q = fwd_hit_r ? fwd_data_r : mem_q;

  // Port arbitration: a load (store wins if both asserted) blocks the drain
  always_comb begin
    load_c      = proc_rden && !proc_wren;
    mem_wren    = (count != '0) && !load_c;
    pop_c       = mem_wren && mem_ready;
`ifdef STORE_BUF_COALESCE_EN
    coal_c      = proc_wren && hit_c && !(pop_c && (hit_idx_c == head));
`else
    coal_c      = 1'b0;
`endif
    alloc_c     = proc_wren && !proc_stall && !coal_c;
    mem_address = load_c ? proc_address : entries[head].addr;
    mem_data    = entries[head].data;
  end

  // FIFO storage, pointers, occupancy and forwarding registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      entries    <= '0;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      fwd_hit_r  <= 1'b0;
      fwd_data_r <= '0;
    end else begin
      fwd_hit_r  <= load_c && hit_c;
      fwd_data_r <= hit_data_c;
      if (pop_c) begin
        entries[head].valid <= 1'b0;
        head                <= head + PW'(1);
      end
      if (coal_c) begin
        entries[hit_idx_c].data <= proc_data;
      end
      if (alloc_c) begin
        entries[tail] <= {1'b1, proc_address, proc_data};
        tail          <= tail + PW'(1);
      end
      count <= count + (PW+1)'(alloc_c) - (PW+1)'(pop_c);
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a queue-based reference model and per-cycle compare.
module tb_store_buffer;
  import store_buf_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned PW    = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] proc_address = '0;
  logic [31:0] proc_data    = '0;
  logic        proc_wren    = 1'b0;
  logic        proc_rden    = 1'b0;
  logic [31:0] proc_q;
  logic        proc_stall;
  logic [31:0] mem_address;
  logic [31:0] mem_data;
  logic        mem_wren;
  logic        mem_ready    = 1'b0;
  logic [31:0] mem_q        = '0;
  logic [PW:0] count;

  int checks   = 0;
  int failures = 0;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .proc_address (proc_address),
    .proc_data    (proc_data),
    .proc_wren    (proc_wren),
    .proc_rden    (proc_rden),
    .proc_q       (proc_q),
    .proc_stall   (proc_stall),
    .mem_address  (mem_address),
    .mem_data     (mem_data),
    .mem_wren     (mem_wren),
    .mem_ready    (mem_ready),
    .mem_q        (mem_q),
    .count        (count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t         wlog[$];
  wr_t         mq[$];
  logic [31:0] dev_mem  [logic [31:0]];
  logic [31:0] gold_mem [logic [31:0]];

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Synchronous memory: one-cycle read latency, write when strobe and ready
  logic [31:0] rd_val;
  initial begin
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) begin
        mem_q = '0;
      end else begin
        rd_val = dev_mem.exists(mem_address) ? dev_mem[mem_address] : init_val(mem_address);
        if (mem_wren && mem_ready) begin
          dev_mem[mem_address] = mem_data;
          wlog.push_back('{mem_address, mem_data});
        end
        mem_q = rd_val;
      end
    end
  end

  // Reference model: a queue of pending stores plus its own view of memory
  bit          q_chk = 1'b0;
  logic [31:0] exp_q = '0;
  int          m_n;
  int          m_j;
  bit          m_ld;
  bit          m_pop;
  bit          m_merged;
  initial begin
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) begin
        mq.delete();
        q_chk = 1'b0;
        exp_q = '0;
      end else begin
        m_n      = mq.size();
        m_ld     = proc_rden && !proc_wren;
        m_pop    = (m_n != 0) && !m_ld && mem_ready;
        m_merged = 1'b0;
        q_chk    = m_ld;
        if (m_ld) begin
          exp_q = gold_mem.exists(proc_address) ? gold_mem[proc_address] : init_val(proc_address);
          foreach (mq[i]) if (mq[i].a == proc_address) exp_q = mq[i].d;
        end
`ifdef STORE_BUF_COALESCE_EN
        m_j = -1;
        if (proc_wren) foreach (mq[i]) if (mq[i].a == proc_address) m_j = i;
        if (m_j >= 0 && !(m_pop && m_j == 0)) begin
          mq[m_j].d = proc_data;
          m_merged  = 1'b1;
        end
`else
        m_j = -1;
`endif
        if (m_pop) begin
          gold_mem[mq[0].a] = mq[0].d;
          void'(mq.pop_front());
        end
        if (proc_wren && !m_merged && m_n != int'(DEPTH)) mq.push_back('{proc_address, proc_data});
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge
  bit c_ld;
  bit c_wren;
  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        c_ld   = proc_rden && !proc_wren;
        c_wren = (mq.size() != 0) && !c_ld;
        chk("count", 32'(count), 32'(mq.size()));
        chk("stall", 32'(proc_stall), 32'(mq.size() == DEPTH));
        chk("mem_wren", 32'(mem_wren), 32'(c_wren));
        if (c_wren) begin
          chk("drain_addr", mem_address, mq[0].a);
          chk("drain_data", mem_data, mq[0].d);
        end
        if (c_ld) chk("load_addr", mem_address, proc_address);
        if (q_chk) chk("proc_q", proc_q, exp_q);
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    bit ok;
    ok           = 1'b0;
    proc_wren    = 1'b1;
    proc_rden    = 1'b0;
    proc_address = a;
    proc_data    = d;
    for (int n = 0; n < 64 && !ok; n++) begin
      @(negedge clock);
      ok = !proc_stall;
      cyc();
    end
    proc_wren = 1'b0;
    chk("store_accept", 32'(ok), 32'd1);
  endtask

  task automatic load(input logic [31:0] a);
    proc_rden    = 1'b1;
    proc_wren    = 1'b0;
    proc_address = a;
    cyc();
    proc_rden = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done      = 1'b0;
    proc_wren = 1'b0;
    proc_rden = 1'b0;
    mem_ready = 1'b1;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clock);
      done = (count == '0);
    end
    chk("drain_done", 32'(count), 32'd0);
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Async reset from power-up
    #1 reset = 1'b0;
    #2;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_mem_wren", 32'(mem_wren), 32'd0);
    chk("rst_stall", 32'(proc_stall), 32'd0);
    chk("rst_proc_q", proc_q, 32'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    cyc();

    // Fill to full with memory not ready, then drain in order
    wlog.delete();
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) store(32'h10 + 32'(i), 32'hA0 + 32'(i));
    chk("full_count", 32'(count), 32'd4);
    proc_wren    = 1'b1;
    proc_address = 32'h14;
    proc_data    = 32'hA4;
    @(negedge clock);
    chk("full_stall", 32'(proc_stall), 32'd1);
    cyc();
    mem_ready = 1'b1;
    store(32'h14, 32'hA4);
    drain();
    chk("fill_nwrites", 32'(wlog.size()), 32'd5);
    for (int i = 0; i < 5 && i < wlog.size(); i++) begin
      chk("fill_order_a", wlog[i].a, 32'h10 + 32'(i));
      chk("fill_order_d", wlog[i].d, 32'hA0 + 32'(i));
    end

    // Same-address stores, load forwards the youngest data
    wlog.delete();
    mem_ready = 1'b0;
    store(32'h20, 32'h11);
    store(32'h20, 32'h22);
`ifdef STORE_BUF_COALESCE_EN
    chk("dup_count", 32'(count), 32'd1);
`else
    chk("dup_count", 32'(count), 32'd2);
`endif
    load(32'h20);
    @(negedge clock);
    chk("fwd_q", proc_q, 32'h22);
    chk("fwd_no_write", 32'(wlog.size()), 32'd0);
    drain();
`ifdef STORE_BUF_COALESCE_EN
    chk("dup_nwrites", 32'(wlog.size()), 32'd1);
`else
    chk("dup_nwrites", 32'(wlog.size()), 32'd2);
`endif
    chk("dup_final", dev_mem[32'h20], 32'h22);

    // Missing load blocks the drain for one cycle, reads memory
    wlog.delete();
    mem_ready = 1'b0;
    store(32'h50, 32'h5);
    store(32'h51, 32'h6);
    mem_ready    = 1'b1;
    proc_rden    = 1'b1;
    proc_address = 32'h30;
    @(negedge clock);
    chk("miss_wren", 32'(mem_wren), 32'd0);
    chk("miss_addr", mem_address, 32'h30);
    cyc();
    proc_rden = 1'b0;
    @(negedge clock);
    chk("miss_q", proc_q, 32'hC0DE_0030);
    chk("miss_resume", 32'(mem_wren), 32'd1);
    chk("miss_count", 32'(count), 32'd2);
    drain();

    // Concurrent enqueue and pop at count=2, pointers wrap
    wlog.delete();
    mem_ready = 1'b0;
    store(32'h60, 32'hB0);
    store(32'h61, 32'hB1);
    mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      store(32'h62 + 32'(i), 32'hB2 + 32'(i));
      chk("wrap_count", 32'(count), 32'd2);
    end
    drain();
    chk("wrap_nwrites", 32'(wlog.size()), 32'd8);
    for (int i = 0; i < 8 && i < wlog.size(); i++) begin
      chk("wrap_order_a", wlog[i].a, 32'h60 + 32'(i));
      chk("wrap_order_d", wlog[i].d, 32'hB0 + 32'(i));
    end

    // Reset mid-activity clears everything immediately
    mem_ready = 1'b0;
    store(32'h70, 32'h77);
    load(32'h70);
    chk("pre_rst_q", proc_q, 32'h77);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_wren", 32'(mem_wren), 32'd0);
    chk("mid_rst_stall", 32'(proc_stall), 32'd0);
    chk("mid_rst_q", proc_q, 32'd0);
    @(posedge clock);
    #1 reset = 1'b1;
    cyc();
    chk("post_rst_count", 32'(count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
